// File: rtl/alu_arb_pkg.sv
// Shared state encoding and constants for the two-port ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned OP_W = 4;
  localparam logic        P0   = 1'b0;
  localparam logic        P1   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] pick,
  output logic       valid
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = (last_gnt == P0) ? 2'b10 : 2'b01;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration.
// Define ALU_TIMEOUT_EN to add a WAIT-state watchdog that completes with err=1.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [OP_W-1:0]   op0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic [OP_W-1:0]   op1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic              busy,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("alu_arbiter: TIMEOUT_CYC must be >= 2");
  end

  state_t     r_state;
  logic       r_sel;
  logic       r_last_gnt;
  logic [1:0] w_pick;
  logic       w_valid;
  logic       w_win;

  rr_arb2 u_rr_arb2 (
    .req      ({req1, req0}),
    .last_gnt (r_last_gnt),
    .pick     (w_pick),
    .valid    (w_valid)
  );

  assign w_win = w_pick[1];

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_wait_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= P0;
      r_last_gnt <= P1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result     <= '0;
      busy       <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_start  <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      err        <= 1'b0;
      r_wait_cnt <= '0;
`endif
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      alu_start <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      err       <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_sel     <= w_win;
            alu_op    <= w_win ? op1 : op0;
            alu_a     <= w_win ? a1 : a0;
            alu_b     <= w_win ? b1 : b0;
            gnt0      <= ~w_win;
            gnt1      <= w_win;
            alu_start <= 1'b1;
            busy      <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef ALU_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state <= WAIT;
        end
        WAIT: begin
          if (alu_done) begin
            result     <= alu_result;
            done0      <= ~r_sel;
            done1      <= r_sel;
            r_last_gnt <= r_sel;
            r_state    <= RESP;
          end
`ifdef ALU_TIMEOUT_EN
          // Watchdog expiry: the 16th (TIMEOUT_CYC-th) WAIT cycle without alu_done
          else if (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            result     <= '0;
            err        <= 1'b1;
            done0      <= ~r_sel;
            done1      <= r_sel;
            r_last_gnt <= r_sel;
            r_state    <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;

  localparam int unsigned DW = 8;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] res;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [3:0]    op0, op1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] result;
  logic          err, busy;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b;
  logic          alu_start;
  logic          alu_done;
  logic [DW-1:0] alu_result;

  logic          m_done, man_done;
  logic [DW-1:0] m_res, man_res, m_calc;
  logic          alu_en;
  int            alu_lat;
  int            errors = 0;
  int            checks = 0;
  int            busy_cnt;
  exp_t          exp_q[$];
  exp_t          mon_e;

  assign alu_done   = m_done | man_done;
  assign alu_result = man_done ? man_res : m_res;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .op0        (op0),
    .a0         (a0),
    .b0         (b0),
    .gnt0       (gnt0),
    .done0      (done0),
    .req1       (req1),
    .op1        (op1),
    .a1         (a1),
    .b1         (b1),
    .gnt1       (gnt1),
    .done1      (done1),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result)
  );

  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      4'h2:    return a + b;
      4'h3:    return a - b;
      4'h4:    return a & b;
      4'h5:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ALU model: answers alu_lat cycles after the start pulse using the presented operands
  initial begin
    m_done = 1'b0;
    m_res  = '0;
    forever begin
      @(negedge clk);
      if (alu_en && alu_start === 1'b1) begin
        m_calc = alu_fn(alu_op, alu_a, alu_b);
        repeat (alu_lat) @(posedge clk);
        #1;
        m_done = 1'b1;
        m_res  = m_calc;
        @(posedge clk);
        #1;
        m_done = 1'b0;
      end
    end
  end

  // Completion monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done0 === 1'b1 || done1 === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", {30'd0, done1, done0}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_port", {30'd0, done1, done0}, mon_e.port ? 32'd2 : 32'd1);
        check("done_result", {24'd0, result}, {24'd0, mon_e.res});
        check("done_err", {31'd0, err}, {31'd0, mon_e.err});
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
    req1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    man_done = 1'b0; man_res = '0;
    alu_en = 1'b1; alu_lat = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {25'd0, gnt0, gnt1, done0, done1, busy, alu_start, err}, 32'd0);
    check("rst_alu", {12'd0, alu_op, alu_a, alu_b}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    rst = 1'b0;

    // Both ports request continuously: grants alternate starting with port 0
    op0 = 4'($urandom_range(2, 5)); a0 = DW'($urandom); b0 = DW'($urandom);
    op1 = 4'($urandom_range(2, 5)); a1 = DW'($urandom); b1 = DW'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_gnt", {30'd0, gnt1, gnt0}, (k % 2 == 1) ? 32'd2 : 32'd1);
      check("rr_start", {31'd0, alu_start}, 32'd1);
      if (k % 2 == 0) begin
        exp_q.push_back('{1'b0, alu_fn(op0, a0, b0), 1'b0});
        op0 = 4'($urandom_range(2, 5)); a0 = DW'($urandom); b0 = DW'($urandom);
      end else begin
        exp_q.push_back('{1'b1, alu_fn(op1, a1, b1), 1'b0});
        op1 = 4'($urandom_range(2, 5)); a1 = DW'($urandom); b1 = DW'($urandom);
      end
      tick(); tick(); tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("rr_idle", {31'd0, busy}, 32'd0);
    check("rr_drain", exp_q.size(), 32'd0);

    // Single request with operand changes after the grant
    op0 = 4'h2; a0 = 8'h05; b0 = 8'h03; req0 = 1'b1;
    exp_q.push_back('{1'b0, 8'h08, 1'b0});
    tick();
    check("single_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    check("single_start", {30'd0, alu_start, busy}, 32'd3);
    check("single_op", {28'd0, alu_op}, 32'h2);
    req0 = 1'b0;
    tick();
    op0 = 4'hF; a0 = 8'hAA;
    check("single_hold_c2", {12'd0, alu_op, alu_a, alu_b}, 32'h2_05_03);
    check("single_c2_pulses", {29'd0, alu_start, gnt0, gnt1}, 32'd0);
    tick();
    check("single_done", {30'd0, done1, done0}, 32'd1);
    check("single_result", {24'd0, result}, 32'h08);
    check("single_hold_c3", {12'd0, alu_op, alu_a, alu_b}, 32'h2_05_03);
    tick();
    check("single_idle", {29'd0, busy, done0, done1}, 32'd0);

    // Slow ALU with a stray alu_done pulse during ISSUE
    alu_en = 1'b0;
    op0 = 4'h3; a0 = 8'h09; b0 = 8'h04; req0 = 1'b1;
    exp_q.push_back('{1'b0, 8'h05, 1'b0});
    tick();
    check("slow_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    man_done = 1'b1; man_res = 8'hEE; req0 = 1'b0;
    tick();
    man_done = 1'b0;
    check("slow_wait", {29'd0, busy, done0, done1}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("slow_busy", {29'd0, busy, done0, done1}, 32'd4);
    end
    man_done = 1'b1; man_res = 8'h05;
    tick();
    man_done = 1'b0;
    check("slow_done", {30'd0, busy, done0}, 32'd3);
    check("slow_result", {24'd0, result}, 32'h05);
    tick();
    check("slow_idle", {31'd0, busy}, 32'd0);

    // Reset while waiting on the ALU discards the operation
    op1 = 4'h5; a1 = 8'h3C; b1 = 8'h0F; req1 = 1'b1;
    tick();
    check("rstw_gnt", {30'd0, gnt1, gnt0}, 32'd2);
    req1 = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("rstw_flags", {25'd0, gnt0, gnt1, done0, done1, busy, alu_start, err}, 32'd0);
    check("rstw_alu", {12'd0, alu_op, alu_a, alu_b}, 32'd0);
    check("rstw_result", {24'd0, result}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    alu_en = 1'b1;
    op1 = 4'h4; a1 = 8'hF0; b1 = 8'h3C; req1 = 1'b1;
    exp_q.push_back('{1'b1, 8'h30, 1'b0});
    tick();
    check("post_rst_gnt", {30'd0, gnt1, gnt0}, 32'd2);
    req1 = 1'b0;
    tick(); tick();
    check("post_rst_done", {30'd0, done1, done0}, 32'd2);
    tick();
    check("post_rst_idle", {31'd0, busy}, 32'd0);

`ifdef ALU_TIMEOUT_EN
    // Watchdog: no alu_done for 16 WAIT cycles
    alu_en = 1'b0;
    op0 = 4'h2; a0 = 8'h01; b0 = 8'h01; req0 = 1'b1;
    exp_q.push_back('{1'b0, 8'h00, 1'b1});
    tick();
    req0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("to_wait", {30'd0, busy, done0}, 32'd2);
    end
    tick();
    check("to_done", {29'd0, done0, err, busy}, 32'd7);
    check("to_result", {24'd0, result}, 32'd0);
    tick();
    check("to_idle", {30'd0, busy, err}, 32'd0);
    // alu_done on the limit edge completes normally
    op0 = 4'h2; a0 = 8'h07; b0 = 8'h01; req0 = 1'b1;
    exp_q.push_back('{1'b0, 8'h08, 1'b0});
    tick();
    req0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("lim_wait", {30'd0, busy, done0}, 32'd2);
    end
    man_done = 1'b1; man_res = 8'h08;
    tick();
    man_done = 1'b0;
    check("lim_done", {29'd0, done0, err, busy}, 32'd5);
    check("lim_result", {24'd0, result}, 32'h08);
    tick();
`else
    // Without the watchdog a silent ALU keeps the arbiter busy
    alu_en = 1'b0;
    op0 = 4'h2; a0 = 8'h01; b0 = 8'h01; req0 = 1'b1;
    tick();
    check("hang_gnt", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
    end
    check("hang_busy", busy_cnt, 32'd40);
    rst = 1'b1;
    #1;
    check("hang_rst", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
`endif

    check("final_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 4-bit-opcode ALU between two requesters (port 0, port 1).
- Round-robin arbitration, operand/opcode latching, ALU start/done sequencing, per-port completion pulse.
- Sits between the opcode sources (test sequencers, future control units) and the ALU. No opcode decoding: any 4-bit value passes through.

Parameters:
- DATA_W, 8, operand and result width.
- TIMEOUT_CYC, 16, WAIT-state watchdog limit in cycles; used only when ALU_TIMEOUT_EN is defined; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request; held high with stable op0/a0/b0 until gnt0.
- op0  in  4  port 0 opcode.
- a0  in  DATA_W  port 0 operand A.
- b0  in  DATA_W  port 0 operand B.
- gnt0  out  1  one-cycle pulse: port 0 request accepted and latched.
- done0  out  1  one-cycle pulse: port 0 result valid.
- req1, op1, a1, b1, gnt1, done1: same as port 0, for port 1.
- result  out  DATA_W  last captured ALU result; held until next capture.
- err  out  1  high with doneN when the operation timed out.
- busy  out  1  high in any state other than IDLE.
- alu_op  out  4  opcode to ALU.
- alu_a  out  DATA_W  operand A to ALU.
- alu_b  out  DATA_W  operand B to ALU.
- alu_start  out  1  one-cycle start pulse to ALU.
- alu_done  in  1  ALU completion; sampled only in WAIT.
- alu_result  in  DATA_W  ALU result; valid while alu_done is high.

Behaviour:
- All outputs are registered or decoded from state. Reset values: all outputs 0, state IDLE, last_gnt=1, so port 0 wins the first tie.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Only req0 high -> select port 0. Only req1 high -> select port 1.
  - Both high -> select the port != last_gnt.
  - On selection: latch op/a/b of the winner into alu_op/alu_a/alu_b, record sel, go ISSUE.
  - No request -> stay in IDLE.
- ISSUE (1 cycle): gnt[sel]=1 and alu_start=1. Go WAIT.
- WAIT:
  - alu_done=1 -> capture alu_result into result, go RESP.
  - Otherwise stay in WAIT.
- RESP (1 cycle): done[sel]=1, err per watchdog, last_gnt<=sel. Go IDLE.
- alu_op/alu_a/alu_b are stable from ISSUE through RESP.
- Minimum latency: req sampled at edge 0; gnt/alu_start high in cycle 1; done in cycle 3 when the ALU raises done the cycle after start.
- Back-to-back: throughput is at most one operation per 4 cycles. A request held through RESP is re-arbitrated in IDLE on the next edge.
- Request rules:
  - reqN dropped after gnt: no effect, operation completes.
  - reqN dropped before gnt: that request is withdrawn.
  - A port must not re-raise req before its doneN pulse.
- Signals ignored outside WAIT: alu_done in ISSUE, IDLE or RESP; alu_result.
- Reset mid-operation: immediate return to reset values, in-flight operation discarded with no doneN. The ALU is reset by the same rst.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - Count reaches TIMEOUT_CYC without alu_done -> go RESP with result<=0 and err=1 for the doneN cycle.
  - alu_done on the same edge as the limit -> normal completion, err=0.
- Undefined: WAIT is unbounded, err is tied 0, no counter logic.

Decomposition:
- Package alu_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - OP_W=4;
  - port-index constants P0=0, P1=1.
- Sub-module rr_arb2 (natural split):
  - inputs: req[1:0], last_gnt;
  - outputs: one-hot pick and valid;
  - purely combinational, reused by future N-port versions.

Test Plan:
- Single request: req0=1, op0=4'b0010, a0=8'h05, b0=8'h03; ALU returns 8'h08 the cycle after start -> gnt0 in cycle 1, alu_op=0010 during cycles 1-3, done0 in cycle 3, result=8'h08, gnt1/done1 stay 0.
- Simultaneous requests from reset: req0=req1=1 continuously -> grant order 0,1,0,1; each doneN matches its port's operands; no port granted twice in a row.
- Slow ALU: alu_done delayed 5 cycles; alu_done pulsed during ISSUE -> ignored in ISSUE; done0 arrives 5 cycles later; busy stays high throughout.
- Reset mid-WAIT: assert rst in WAIT -> all outputs 0 asynchronously, no done pulse. After release, req1 alone -> granted normally.
- Timeout (ALU_TIMEOUT_EN defined, TIMEOUT_CYC=16): alu_done never asserted -> done0 with err=1 and result=0 exactly 16 WAIT cycles after entry. Without the macro, bench observes busy held indefinitely.
- Operand stability: change a0 and op0 on the cycle after gnt0 -> alu_a and alu_op keep the latched values until RESP.
